axi4_lite_write_master_engine: RTL

- Parametrised AXI4-Lite write master engine that sits between the write-master agent's command side and the AXI4-Lite write channels (AW, W, B).
- Accepts write commands in either blocking or non-blocking mode. Issues AW and W independently and tracks up to MAX_OUTSTANDING in-flight writes.
- Enforces a configurable legal address window, swaps byte lanes for big-endian commands, and returns ordered responses through a response FIFO.

---
 rtl/axi4_lite_write_master_engine.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_write_master_engine.sv
// AXI4-Lite write master engine.
// Accepts blocking / non-blocking write commands, range-checks the address against a
// configurable window, optionally byte-swaps the payload, issues AW and W independently,
// tracks in-flight writes and returns responses in command order through a FWFT FIFO.
//
// Ports:
//   aclk, areset                     clock, synchronous active-high reset
//   cfg_min/max_address, cfg_endian  legal window (inclusive) and endianness (0=big)
//   cmd_*                            command handshake and payload
//   aw*, w*, b*                      AXI4-Lite write channels
//   rsp_*                            ordered response FIFO output (rsp_local=1: local DECERR)
//   outstanding                      writes issued without B
//   err_unexpected_b                 sticky: B seen with nothing outstanding
module axi4_lite_write_master_engine #(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [ADDRESS_WIDTH-1:0]  cfg_min_address,
  input  logic [ADDRESS_WIDTH-1:0]  cfg_max_address,
  input  logic                      cfg_endian,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [2:0]                cmd_prot,
  input  logic [DATA_WIDTH-1:0]     cmd_data,
  input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
  input  logic [1:0]                cmd_type,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ADDRESS_WIDTH-1:0]  awaddr,
  output logic [2:0]                awprot,
  output logic                      wvalid,
  input  logic                      wready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_local,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      err_unexpected_b
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned PtrW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W:0]  MaxOut  = (CNT_W + 1)'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitB, StLocalErr} state_e;

  state_e              state;
  logic                blocking_q;
  logic [2:0]          fifo_mem [MAX_OUTSTANDING];
  logic [PtrW-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    fifo_count;

  logic                cmd_blocking, credit_ok, cmd_fire, addr_legal;
  logic                aw_fire, w_fire, issue_done, b_fire, b_ok, local_push, push, pop;
  logic [2:0]          push_data;
  logic [DATA_WIDTH-1:0] swap_data;
  logic [StrbW-1:0]    swap_strb;

  // Only 2'b10 is non-blocking; the reserved encodings fall back to blocking.
  assign cmd_blocking = (cmd_type != 2'b10);
  // In-flight writes plus queued responses must leave room for this command's response.
  assign credit_ok  = ({1'b0, outstanding} + {1'b0, fifo_count}) < MaxOut;
  // bready doubles as the "out of reset" flag so cmd_ready stays low for one cycle.
  assign cmd_ready  = bready && (state == StIdle) && credit_ok &&
                      (!cmd_blocking || (outstanding == '0));
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign addr_legal = (cmd_addr >= cfg_min_address) && (cmd_addr <= cfg_max_address);

  assign aw_fire    = awvalid && awready;
  assign w_fire     = wvalid && wready;
  // A channel already handshaken has its valid low, so it counts as done.
  assign issue_done = (state == StIssue) && (!awvalid || awready) && (!wvalid || wready);

  assign b_fire     = bvalid && bready;
  assign b_ok       = b_fire && (outstanding != '0);
  // Local error waits until every earlier bus write has reported, keeping order.
  assign local_push = (state == StLocalErr) && (outstanding == '0);
  assign push       = b_ok || local_push;
  assign push_data  = b_ok ? {bresp, 1'b0} : {2'b11, 1'b1};
  assign pop        = rsp_valid && rsp_ready;

  assign rsp_valid  = (fifo_count != '0);
  assign rsp_resp   = rsp_valid ? fifo_mem[rd_ptr][2:1] : 2'b00;
  assign rsp_local  = rsp_valid ? fifo_mem[rd_ptr][0] : 1'b0;

  always_comb begin
    swap_data = '0;
    swap_strb = '0;
    for (int unsigned i = 0; i < StrbW; i++) begin
      swap_data[8*i +: 8] = cmd_data[8*(StrbW-1-i) +: 8];
      swap_strb[i]        = cmd_strb[StrbW-1-i];
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset && push) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state            <= StIdle;
      blocking_q       <= 1'b0;
      bready           <= 1'b0;
      awvalid          <= 1'b0;
      awaddr           <= '0;
      awprot           <= '0;
      wvalid           <= 1'b0;
      wdata            <= '0;
      wstrb            <= '0;
      outstanding      <= '0;
      err_unexpected_b <= 1'b0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      fifo_count       <= '0;
    end else begin
      bready <= 1'b1;

      if (issue_done && !b_ok) begin
        outstanding <= outstanding + CNT_W'(1);
      end else if (!issue_done && b_ok) begin
        outstanding <= outstanding - CNT_W'(1);
      end

      if (b_fire && (outstanding == '0)) begin
        err_unexpected_b <= 1'b1;
      end

      if (push) begin
        wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end

      unique case (state)
        StIdle: begin
          if (cmd_fire) begin
            blocking_q <= cmd_blocking;
            if (addr_legal) begin
              state   <= StIssue;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              awaddr  <= cmd_addr;
              awprot  <= cmd_prot;
              wdata   <= cfg_endian ? cmd_data : swap_data;
              wstrb   <= cfg_endian ? cmd_strb : swap_strb;
            end else begin
              state <= StLocalErr;
            end
          end
        end
        StIssue: begin
          if (aw_fire) awvalid <= 1'b0;
          if (w_fire)  wvalid  <= 1'b0;
          if (issue_done) begin
            state <= blocking_q ? StWaitB : StIdle;
          end
        end
        StWaitB: begin
          if (outstanding == '0) state <= StIdle;
        end
        StLocalErr: begin
          if (local_push) state <= StIdle;
        end
      endcase
    end
  end

endmodule
